// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: shared pipeline forwarding encodings and register-index width
package ex_mem_reg_pkg;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;
endpackage

// File: rtl/ex_mem_reg_forward_unit.sv
// forward_unit: EX/MEM and MEM/WB operand forwarding select plus load-use detect
module forward_unit
  import ex_mem_reg_pkg::*;
(
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic             mem_mem_to_reg,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             load_use
);
  logic mem_ok, wb_ok;
  always_comb begin
    mem_ok = mem_valid & mem_reg_write & ~mem_mem_to_reg & |mem_rd;
    wb_ok = wb_reg_write & |wb_rd;
    fwd_a = (mem_ok && mem_rd == id_rs) ? FWD_MEM : (wb_ok && wb_rd == id_rs) ? FWD_WB : FWD_NONE;
    fwd_b = (mem_ok && mem_rd == id_rt) ? FWD_MEM : (wb_ok && wb_rd == id_rt) ? FWD_WB : FWD_NONE;
    load_use = mem_valid & mem_mem_to_reg & |mem_rd & (mem_rd == id_rs | mem_rd == id_rt);
  end
endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with stall/flush, forwarding and stall counter
module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [31:0]      ex_alu_res,
  input  logic [31:0]      ex_store_data,
  input  logic             ex_mem_write,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  output logic             mem_valid,
  output logic [31:0]      ALURes,
  output logic [31:0]      RdRqIn,
  output logic             Mem_Write,
  output logic             mem_reg_write,
  output logic             mem_mem_to_reg,
  output logic [REG_W-1:0] mem_rd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             load_use,
  output logic [15:0]      stall_cnt
);
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_valid <= 1'b0;
      ALURes <= '0;
      RdRqIn <= '0;
      Mem_Write <= 1'b0;
      mem_reg_write <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_rd <= '0;
    end else if (!stall) begin
      mem_valid <= ex_valid;
      ALURes <= ex_alu_res;
      RdRqIn <= ex_store_data;
      Mem_Write <= ex_mem_write & ex_valid;
      mem_reg_write <= ex_reg_write & ex_valid;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_rd <= ex_rd;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (stall && !flush && !(&stall_cnt)) stall_cnt <= stall_cnt + 16'd1;
  end
  forward_unit u_fwd (
    .mem_valid(mem_valid),
    .mem_reg_write(mem_reg_write),
    .mem_mem_to_reg(mem_mem_to_reg),
    .mem_rd(mem_rd),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .load_use(load_use)
  );
endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: table, directed and randomized checks of ex_mem_reg against a reference model
module tb_ex_mem_reg;
  logic clk = 0, rst, stall, flush, ex_valid, ex_mem_write, ex_reg_write, ex_mem_to_reg, wb_reg_write;
  logic [31:0] ex_alu_res, ex_store_data;
  logic [4:0] ex_rd, id_rs, id_rt, wb_rd;
  logic mem_valid, Mem_Write, mem_reg_write, mem_mem_to_reg, load_use;
  logic [31:0] ALURes, RdRqIn;
  logic [4:0] mem_rd;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data),
    .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
    .id_rs(id_rs), .id_rt(id_rt), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .mem_valid(mem_valid), .ALURes(ALURes), .RdRqIn(RdRqIn), .Mem_Write(Mem_Write),
    .mem_reg_write(mem_reg_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .load_use(load_use), .stall_cnt(stall_cnt)
  );
  typedef struct packed {
    logic valid;
    logic [31:0] alu, sd;
    logic mw, rw, m2r;
    logic [4:0] rd;
    logic [15:0] cnt;
  } st_t;
  st_t m;
  typedef struct packed {
    logic rst, flush, stall, v;
    logic [31:0] alu;
    logic mw, rw, m2r;
    logic [4:0] rd, rs, rt;
    logic wrw;
    logic [4:0] wrd;
    logic e_valid;
    logic [31:0] e_alu;
    logic e_mw, e_rw;
    logic [4:0] e_rd;
    logic [1:0] e_fa, e_fb;
    logic e_lu;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  function automatic logic [1:0] exp_fwd(logic [4:0] src);
    if (m.valid && m.rw && !m.m2r && m.rd != 0 && m.rd == src) return 2'b10;
    if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction
  function automatic logic exp_lu();
    return m.valid && m.m2r && m.rd != 0 && (m.rd == id_rs || m.rd == id_rt);
  endfunction
  task automatic upd();
    st_t n;
    n = m;
    if (rst) n = '0;
    else begin
      if (stall && !flush && m.cnt != 16'hFFFF) n.cnt = m.cnt + 1;
      if (flush) begin
        n = '0;
        n.cnt = m.cnt;
      end else if (!stall) begin
        n.valid = ex_valid;
        n.alu = ex_alu_res;
        n.sd = ex_store_data;
        n.mw = ex_valid && ex_mem_write;
        n.rw = ex_valid && ex_reg_write;
        n.m2r = ex_mem_to_reg;
        n.rd = ex_rd;
      end
    end
    m = n;
  endtask
  task automatic tick();
    @(posedge clk);
    upd();
    #1;
  endtask
  task automatic check_comb(string t);
    chk({t, ".fwd_a"}, 32'(fwd_a), 32'(exp_fwd(id_rs)));
    chk({t, ".fwd_b"}, 32'(fwd_b), 32'(exp_fwd(id_rt)));
    chk({t, ".load_use"}, 32'(load_use), 32'(exp_lu()));
  endtask
  task automatic check_all(string t);
    chk({t, ".mem_valid"}, 32'(mem_valid), 32'(m.valid));
    chk({t, ".ALURes"}, ALURes, m.alu);
    chk({t, ".RdRqIn"}, RdRqIn, m.sd);
    chk({t, ".Mem_Write"}, 32'(Mem_Write), 32'(m.mw));
    chk({t, ".mem_reg_write"}, 32'(mem_reg_write), 32'(m.rw));
    chk({t, ".mem_mem_to_reg"}, 32'(mem_mem_to_reg), 32'(m.m2r));
    chk({t, ".mem_rd"}, 32'(mem_rd), 32'(m.rd));
    chk({t, ".stall_cnt"}, 32'(stall_cnt), 32'(m.cnt));
    check_comb(t);
  endtask
  initial begin
    m = '0;
    {rst, stall, flush, ex_valid, ex_mem_write, ex_reg_write, ex_mem_to_reg, wb_reg_write} = 8'h80;
    {ex_alu_res, ex_store_data} = '0;
    {ex_rd, id_rs, id_rt, wb_rd} = '0;
    tbl = '{
      '{1,0,0,0,32'h0,0,0,0,5'd0,5'd0,5'd0,0,5'd0, 0,32'h0,0,0,5'd0,2'd0,2'd0,0,16'd0},
      '{0,0,0,1,32'h1234,1,0,0,5'd0,5'd0,5'd0,0,5'd0, 1,32'h1234,1,0,5'd0,2'd0,2'd0,0,16'd0},
      '{0,0,1,1,32'hFFFF,0,1,0,5'd9,5'd0,5'd0,0,5'd0, 1,32'h1234,1,0,5'd0,2'd0,2'd0,0,16'd1},
      '{0,0,1,1,32'hFFFF,0,1,0,5'd9,5'd0,5'd0,0,5'd0, 1,32'h1234,1,0,5'd0,2'd0,2'd0,0,16'd2},
      '{0,0,1,1,32'hFFFF,0,1,0,5'd9,5'd0,5'd0,0,5'd0, 1,32'h1234,1,0,5'd0,2'd0,2'd0,0,16'd3},
      '{0,1,1,1,32'hFFFF,1,1,0,5'd9,5'd0,5'd0,0,5'd0, 0,32'h0,0,0,5'd0,2'd0,2'd0,0,16'd3},
      '{0,0,0,1,32'h55,0,1,0,5'd5,5'd5,5'd5,1,5'd5, 1,32'h55,0,1,5'd5,2'd2,2'd2,0,16'd3},
      '{0,0,0,1,32'h66,0,1,0,5'd0,5'd5,5'd5,1,5'd5, 1,32'h66,0,1,5'd0,2'd1,2'd1,0,16'd3},
      '{0,0,0,1,32'h77,0,1,1,5'd7,5'd3,5'd7,1,5'd7, 1,32'h77,0,1,5'd7,2'd0,2'd1,1,16'd3},
      '{0,0,0,1,32'h99,0,1,1,5'd0,5'd3,5'd7,0,5'd0, 1,32'h99,0,1,5'd0,2'd0,2'd0,0,16'd3},
      '{0,0,0,0,32'h88,1,1,0,5'd4,5'd4,5'd4,0,5'd0, 0,32'h88,0,0,5'd4,2'd0,2'd0,0,16'd3},
      '{1,0,1,1,32'hAB,1,1,0,5'd2,5'd2,5'd0,1,5'd2, 0,32'h0,0,0,5'd0,2'd1,2'd0,0,16'd0},
      '{0,0,1,1,32'hAB,1,1,0,5'd2,5'd0,5'd0,0,5'd0, 0,32'h0,0,0,5'd0,2'd0,2'd0,0,16'd1},
      '{1,1,0,1,32'hAB,1,1,0,5'd2,5'd0,5'd0,0,5'd0, 0,32'h0,0,0,5'd0,2'd0,2'd0,0,16'd0}
    };
    for (int i = 0; i < 14; i++) begin
      {rst, flush, stall, ex_valid} = {tbl[i].rst, tbl[i].flush, tbl[i].stall, tbl[i].v};
      ex_alu_res = tbl[i].alu;
      ex_store_data = tbl[i].alu ^ 32'hDEAD_BEEF;
      {ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_rd} = {tbl[i].mw, tbl[i].rw, tbl[i].m2r, tbl[i].rd};
      {id_rs, id_rt, wb_reg_write, wb_rd} = {tbl[i].rs, tbl[i].rt, tbl[i].wrw, tbl[i].wrd};
      tick();
      chk($sformatf("v%0d.mem_valid", i), 32'(mem_valid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d.ALURes", i), ALURes, tbl[i].e_alu);
      chk($sformatf("v%0d.Mem_Write", i), 32'(Mem_Write), 32'(tbl[i].e_mw));
      chk($sformatf("v%0d.mem_reg_write", i), 32'(mem_reg_write), 32'(tbl[i].e_rw));
      chk($sformatf("v%0d.mem_rd", i), 32'(mem_rd), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d.fwd_a", i), 32'(fwd_a), 32'(tbl[i].e_fa));
      chk($sformatf("v%0d.fwd_b", i), 32'(fwd_b), 32'(tbl[i].e_fb));
      chk($sformatf("v%0d.load_use", i), 32'(load_use), 32'(tbl[i].e_lu));
      chk($sformatf("v%0d.stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d.RdRqIn", i), RdRqIn, m.sd);
    end
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 49) == 0;
      flush = $urandom_range(0, 9) == 0;
      stall = $urandom_range(0, 3) == 0;
      ex_valid = $urandom_range(0, 3) != 0;
      ex_alu_res = $urandom;
      ex_store_data = $urandom;
      {ex_mem_write, ex_reg_write, ex_mem_to_reg, wb_reg_write} = 4'($urandom);
      ex_rd = 5'($urandom_range(0, 7));
      id_rs = 5'($urandom_range(0, 7));
      id_rt = 5'($urandom_range(0, 7));
      wb_rd = 5'($urandom_range(0, 7));
      #1;
      check_comb($sformatf("pre%0d", i));
      tick();
      check_all($sformatf("rnd%0d", i));
    end
    {rst, flush, stall} = 3'b001;
    repeat (65540) tick();
    chk("sat.stall_cnt", 32'(stall_cnt), 32'h0000_FFFF);
    check_all("sat");
    {rst, flush, stall} = 3'b100;
    tick();
    chk("rst.stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst.mem_valid", 32'(mem_valid), 32'h0);
    check_all("rst");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: stall  in  1  hold current contents (memory stage not ready).
REQ-004 SHALL have port: flush  in  1  replace next contents with a bubble (branch/exception squash).
REQ-005 SHALL have ports: ex_valid in 1; ex_alu_res in 32; ex_store_data in 32; ex_mem_write in 1; ex_reg_write in 1; ex_mem_to_reg in 1; ex_rd in 5  (execute-stage results and controls).
REQ-006 SHALL have ports: id_rs in 5; id_rt in 5  (source registers of the instruction entering execute).
REQ-007 SHALL have ports: wb_reg_write in 1; wb_rd in 5  (write-back stage destination).
REQ-008 SHALL have ports: mem_valid out 1; ALURes out 32; RdRqIn out 32; Mem_Write out 1; mem_reg_write out 1; mem_mem_to_reg out 1; mem_rd out 5  (registered outputs feeding the memory stage).
REQ-009 SHALL have ports: fwd_a out 2; fwd_b out 2; load_use out 1; stall_cnt out 16.

Function
REQ-010 SHALL update registered outputs with priority rst > flush > stall > load.
REQ-011 load (no rst/flush/stall) SHALL capture all ex_* inputs into the corresponding outputs in one cycle; latency 1 clock.
REQ-012 flush SHALL clear mem_valid, Mem_Write, mem_reg_write and mem_mem_to_reg; data fields (ALURes, RdRqIn, mem_rd) SHALL be don't-care but are cleared to 0.
REQ-013 flush SHALL win over a simultaneous stall: result is a bubble, not a hold.
REQ-014 stall SHALL hold every registered output unchanged, including Mem_Write, so a stalled store presents stable address/data.
REQ-015 Mem_Write and mem_reg_write SHALL be forced 0 whenever the captured ex_valid is 0.
REQ-016 fwd_a (combinational) SHALL be 2'b10 when mem_valid & mem_reg_write & !mem_mem_to_reg & mem_rd!=0 & mem_rd==id_rs; else 2'b01 when wb_reg_write & wb_rd!=0 & wb_rd==id_rs; else 2'b00.
REQ-017 fwd_b SHALL follow REQ-016 with id_rt in place of id_rs.
REQ-018 EX/MEM match SHALL take priority over MEM/WB match when both hit.
REQ-019 load_use SHALL be 1 when mem_valid & mem_mem_to_reg & mem_rd!=0 & (mem_rd==id_rs | mem_rd==id_rt); fwd_a/fwd_b SHALL NOT select 2'b10 for that operand.
REQ-020 register 0 (rd==0) SHALL never produce a forward or load_use.
REQ-021 stall_cnt SHALL increment by 1 each cycle stall=1 and flush=0, saturating at 16'hFFFF (no wrap).

Reset
REQ-022 On rst at a rising edge: mem_valid, Mem_Write, mem_reg_write, mem_mem_to_reg = 0; ALURes, RdRqIn = 32'h0; mem_rd = 0; stall_cnt = 0.
REQ-023 rst asserted mid-stall or together with flush SHALL yield the reset state on the next edge.
REQ-024 fwd_a, fwd_b, load_use SHALL be 0 during and immediately after reset unless wb_* inputs match.

Structure
REQ-025 Forward-select encodings (FWD_NONE=00, FWD_WB=01, FWD_MEM=10) and register-index width (5) SHALL live in the shared pipeline package.
REQ-026 Forwarding/load-use comparison SHALL be a sub-module named forward_unit, instantiated once; the register bank and stall counter stay in ex_mem_reg.

Verification
REQ-027 Load: ex_alu_res=32'h0000_1234, ex_mem_write=1, ex_valid=1, no stall -> next cycle ALURes=32'h0000_1234, Mem_Write=1, mem_valid=1.
REQ-028 Stall: store captured, then stall=1 for 3 cycles with new ex_* values -> outputs unchanged for 3 cycles; stall_cnt=3.
REQ-029 Flush+stall same cycle with valid store held -> next cycle Mem_Write=0, mem_valid=0, stall_cnt unchanged.
REQ-030 Forward: mem_rd=5, mem_reg_write=1, wb_rd=5, wb_reg_write=1, id_rs=5 -> fwd_a=2'b10; id_rt=5, mem_rd=0 -> fwd_b=2'b01.
REQ-031 Load-use: mem_mem_to_reg=1, mem_rd=7, id_rt=7 -> load_use=1, fwd_b!=2'b10; mem_rd=0 -> load_use=0.
REQ-032 Saturation/reset: stall held 65540 cycles -> stall_cnt=16'hFFFF; then rst=1 one edge -> all outputs at REQ-022 values.
